// File: rtl/register_7bit_inc_arb.sv
// Two 7-bit channel registers sharing one +1 incrementer, with round-robin arbitration between them.
// Optional build macro REGISTER_INC_SATURATE_EN: an increment of 7'h7F holds 7'h7F instead of wrapping to 7'h00.
module register_7bit_inc_arb #(
    parameter logic [6:0] RST_A = 7'h00,
    parameter logic [6:0] RST_B = 7'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic       LD_A,
    input  logic       LD_B,
    input  logic [6:0] LDV_A,
    input  logic [6:0] LDV_B,
    output logic [6:0] Q_A,
    output logic [6:0] Q_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       WRAP_A,
    output logic       WRAP_B,
    output logic       LAST
);

    logic [6:0] q_a_reg, q_a_next;
    logic [6:0] q_b_reg, q_b_next;
    logic       gnt_a_reg, gnt_a_next;
    logic       gnt_b_reg, gnt_b_next;
    logic       wrap_a_reg, wrap_a_next;
    logic       wrap_b_reg, wrap_b_next;
    logic       last_reg, last_next;

    logic       elig_a, elig_b;
    logic       win_a, win_b;

    logic [6:0] inc_in;
    logic [6:0] inc_not_in;
    logic [6:0] inc_sum;
    logic [7:0] inc_carry;
    logic       inc_overflow;
    logic [6:0] inc_result;

    // A channel that is loading this cycle does not compete for the incrementer.
    assign elig_a = REQ_A & ~LD_A;
    assign elig_b = REQ_B & ~LD_B;

    // On a tie the channel not served last wins; last_reg = 1 means B was served last.
    assign win_b = elig_b & (~elig_a | ~last_reg);
    assign win_a = elig_a & ~win_b;

    assign inc_in     = win_b ? q_b_reg : q_a_reg;
    assign inc_not_in = ~inc_in;
    assign inc_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_inc
            assign inc_sum[gi]       = inc_carry[gi] ? inc_not_in[gi] : inc_in[gi];
            assign inc_carry[gi + 1] = inc_carry[gi] & inc_in[gi];
        end
    endgenerate

    assign inc_overflow = inc_carry[7];

`ifdef REGISTER_INC_SATURATE_EN
    assign inc_result = inc_overflow ? 7'h7F : inc_sum;
`else
    assign inc_result = inc_sum;
`endif

    always_comb begin
        q_a_next    = q_a_reg;
        q_b_next    = q_b_reg;
        gnt_a_next  = win_a;
        gnt_b_next  = win_b;
        wrap_a_next = win_a & inc_overflow;
        wrap_b_next = win_b & inc_overflow;
        last_next   = last_reg;

        if (LD_A)
            q_a_next = LDV_A;
        else if (win_a)
            q_a_next = inc_result;

        if (LD_B)
            q_b_next = LDV_B;
        else if (win_b)
            q_b_next = inc_result;

        if (win_a)
            last_next = 1'b0;
        else if (win_b)
            last_next = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_a_reg    <= RST_A;
            q_b_reg    <= RST_B;
            gnt_a_reg  <= 1'b0;
            gnt_b_reg  <= 1'b0;
            wrap_a_reg <= 1'b0;
            wrap_b_reg <= 1'b0;
            last_reg   <= 1'b1;
        end else begin
            q_a_reg    <= q_a_next;
            q_b_reg    <= q_b_next;
            gnt_a_reg  <= gnt_a_next;
            gnt_b_reg  <= gnt_b_next;
            wrap_a_reg <= wrap_a_next;
            wrap_b_reg <= wrap_b_next;
            last_reg   <= last_next;
        end
    end

    assign Q_A    = q_a_reg;
    assign Q_B    = q_b_reg;
    assign GNT_A  = gnt_a_reg;
    assign GNT_B  = gnt_b_reg;
    assign WRAP_A = wrap_a_reg;
    assign WRAP_B = wrap_b_reg;
    assign LAST   = last_reg;

endmodule

// File: tb/tb_register_7bit_inc_arb.sv
// Directed bench for register_7bit_inc_arb; observed vector is {Q_A, Q_B, GNT_A, GNT_B, WRAP_A, WRAP_B, LAST}.
module tb_register_7bit_inc_arb;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_A = 1'b0, REQ_B = 1'b0;
    logic       LD_A = 1'b0, LD_B = 1'b0;
    logic [6:0] LDV_A = 7'h00, LDV_B = 7'h00;
    logic [6:0] Q_A, Q_B;
    logic       GNT_A, GNT_B, WRAP_A, WRAP_B, LAST;

    logic [18:0] obs;
    int          check_count = 0;
    int          pass_count = 0;

    register_7bit_inc_arb #(.RST_A(7'h00), .RST_B(7'h00)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .LD_A(LD_A), .LD_B(LD_B),
        .LDV_A(LDV_A), .LDV_B(LDV_B),
        .Q_A(Q_A), .Q_B(Q_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .WRAP_A(WRAP_A), .WRAP_B(WRAP_B),
        .LAST(LAST)
    );

    always #5 CLK = ~CLK;

    assign obs = {Q_A, Q_B, GNT_A, GNT_B, WRAP_A, WRAP_B, LAST};

    task automatic step();
        @(posedge CLK);
        #1;
        $display("t=%0t Q_A=%h Q_B=%h GNT=%b%b WRAP=%b%b LAST=%b", $time, Q_A, Q_B, GNT_A, GNT_B, WRAP_A, WRAP_B, LAST);
    endtask

    task automatic idle_inputs();
        REQ_A = 1'b0; REQ_B = 1'b0; LD_A = 1'b0; LD_B = 1'b0;
        LDV_A = 7'h00; LDV_B = 7'h00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] exp;
        idle_inputs();
        step();
        RST = 1'b0;
        step();
        RST = 1'b1;
        #1;
        exp = {7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("FAIL reset_state: got %h want %h", obs, exp);
        else pass_count++;
        step();
        RST = 1'b0;
    endtask

    task automatic test_single_request();
        logic [18:0] exp;
        apply_reset();
        REQ_A = 1'b1;
        step();
        REQ_A = 1'b0;
        exp = {7'h01, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL single_a_grant: got %h want %h", obs, exp);
        else pass_count++;
        step();
        exp = {7'h01, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL single_a_pulse_end: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_alternate();
        logic [18:0] exp_tab [4];
        exp_tab[0] = {7'h01, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_tab[1] = {7'h01, 7'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_tab[2] = {7'h02, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_tab[3] = {7'h02, 7'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        REQ_A = 1'b1; REQ_B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_count++;
            if (obs !== exp_tab[i]) $display("FAIL alternate_%0d: got %h want %h", i, obs, exp_tab[i]);
            else pass_count++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_wrap();
        logic [18:0] exp;
        logic [6:0]  q_after;
`ifdef REGISTER_INC_SATURATE_EN
        q_after = 7'h7F;
`else
        q_after = 7'h00;
`endif
        apply_reset();
        LD_A = 1'b1; LDV_A = 7'h7F;
        step();
        LD_A = 1'b0;
        exp = {7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("FAIL wrap_load: got %h want %h", obs, exp);
        else pass_count++;
        REQ_A = 1'b1;
        step();
        REQ_A = 1'b0;
        exp = {q_after, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL wrap_pulse: got %h want %h", obs, exp);
        else pass_count++;
        step();
        exp = {q_after, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL wrap_pulse_end: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_load_and_inc();
        logic [18:0] exp;
        apply_reset();
        LD_A = 1'b1; LDV_A = 7'h15; REQ_A = 1'b1; REQ_B = 1'b1;
        step();
        LD_A = 1'b0; REQ_B = 1'b0;
        exp = {7'h15, 7'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("FAIL load_with_inc: got %h want %h", obs, exp);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp;
        logic [6:0]  q_exp;
        // REQ_A is still held from the previous scenario; each edge is a fresh request.
        q_exp = 7'h15;
        for (int i = 0; i < 3; i++) begin
            step();
            q_exp = q_exp + 7'h01;
            exp = {q_exp, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            check_count++;
            if (obs !== exp) $display("FAIL back_to_back_%0d: got %h want %h", i, obs, exp);
            else pass_count++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_abort();
        logic [18:0] exp;
        apply_reset();
        LD_B = 1'b1; LDV_B = 7'h33;
        step();
        LD_B = 1'b0;
        exp = {7'h00, 7'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("FAIL abort_load_b: got %h want %h", obs, exp);
        else pass_count++;
        REQ_A = 1'b1; REQ_B = 1'b1;
        step();
        exp = {7'h01, 7'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL abort_b_pending: got %h want %h", obs, exp);
        else pass_count++;
        #3;
        RST = 1'b1;
        #1;
        exp = {7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_count++;
        if (obs !== exp) $display("FAIL abort_async_reset: got %h want %h", obs, exp);
        else pass_count++;
        step();
        check_count++;
        if (obs !== exp) $display("FAIL abort_held_reset: got %h want %h", obs, exp);
        else pass_count++;
        RST = 1'b0;
        step();
        exp = {7'h01, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        check_count++;
        if (obs !== exp) $display("FAIL abort_restart_tie: got %h want %h", obs, exp);
        else pass_count++;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_alternate();
        test_wrap();
        test_load_and_inc();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/register_7bit_inc_arb.md
REGISTER_7BIT_INC_ARB -- requirements
Module: register_7bit_inc_arb

Interface
REQ-001 Parameter: RST_A, 7'h00, reset value of channel A register.
REQ-002 Parameter: RST_B, 7'h00, reset value of channel B register.
REQ-003 Port: CLK  input  1  single clock, all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: REQ_A / REQ_B  input  1 each  increment request for channel A / B; requester holds it until the matching GNT.
REQ-006 Port: LD_A / LD_B  input  1 each  synchronous load strobe for channel A / B.
REQ-007 Port: LDV_A / LDV_B  input  7 each  load value for channel A / B.
REQ-008 Port: Q_A / Q_B  output  7 each  registered channel value.
REQ-009 Port: GNT_A / GNT_B  output  1 each  registered one-cycle grant pulse; high in the cycle in which the updated Q is visible.
REQ-010 Port: WRAP_A / WRAP_B  output  1 each  registered one-cycle pulse on overflow of that channel.
REQ-011 Port: LAST  output  1  round-robin pointer; 0 = A served last, 1 = B served last.

Function
REQ-012 Exactly one shared 7-bit +1 incrementer (In = selected Q, notIn = its bitwise inverse, CY = 1) SHALL serve both channels; at most one increment per cycle.
REQ-013 Arbitration each edge: only REQ_A high -> A wins; only REQ_B high -> B wins; both high -> the channel not equal to LAST wins; neither -> no winner.
REQ-014 Winner: Q_x <= incrementer output at the edge; GNT_x = 1 for the following cycle only; LAST <= winner (0 = A, 1 = B).
REQ-015 Loser: Q unchanged, GNT = 0; its request stays pending and wins at the next edge if still asserted, because LAST now points away from it.
REQ-016 REQ still high while its GNT is high SHALL count as a new request; a REQ dropped before grant is discarded with no effect.
REQ-017 LD_x high: Q_x <= LDV_x at the edge; load overrides increment for that channel; that channel is excluded from arbitration that cycle; GNT_x = 0.
REQ-018 Load on one channel and increment on the other in the same cycle SHALL both take effect.
REQ-019 Overflow: increment of Q_x = 7'h7F gives 7'h00 and WRAP_x = 1 for one cycle alongside GNT_x.
REQ-020 Latency: request to updated Q and GNT = 1 edge uncontended, 2 edges when it loses one tie.

Reset
REQ-021 RST high SHALL immediately force Q_A = RST_A, Q_B = RST_B, GNT_A = GNT_B = 0, WRAP_A = WRAP_B = 0, LAST = 1 (A wins the first tie), independent of CLK.
REQ-022 Reset during a pending or granted operation SHALL abort it; no GNT or WRAP pulse follows deassertion.
REQ-023 The first edge after RST falls SHALL arbitrate normally on the sampled inputs.

Configuration
REQ-024 Macro REGISTER_INC_SATURATE_EN defined: increment of 7'h7F holds Q_x at 7'h7F, GNT_x and WRAP_x still pulse (WRAP indicates saturation).
REQ-025 Macro REGISTER_INC_SATURATE_EN undefined: wrap-around per REQ-019.

Verification
REQ-026 Reset, then REQ_A = 1 for one cycle -> Q_A = 7'h01, GNT_A pulse, LAST = 0, Q_B = 7'h00.
REQ-027 REQ_A and REQ_B held high for 4 cycles from reset -> grants alternate A, B, A, B; Q_A = Q_B = 7'h02.
REQ-028 Q_A loaded to 7'h7F, then REQ_A -> Q_A = 7'h00 with WRAP_A and GNT_A pulses; with REGISTER_INC_SATURATE_EN, Q_A = 7'h7F with both pulses.
REQ-029 LD_A with LDV_A = 7'h15 and REQ_A + REQ_B in the same cycle -> Q_A = 7'h15, GNT_A = 0; Q_B increments, GNT_B = 1.
REQ-030 RST asserted mid-cycle while REQ_B is pending with Q_B = 7'h33 -> Q_B = RST_B at once, no GNT_B; after release, arbitration restarts with A favoured on a tie.
